// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the buffered control decoder.
//   - opcode localparams (instr[8:6])
//   - state_t     : halt FSM states
//   - ctrl_bundle_t: every decoded field and control bit of one instruction
//   - is_halt()   : recognises the halt encoding
//   - decode()    : 9-bit instruction -> ctrl_bundle_t
package ctrl_pkg;

    localparam logic [2:0] OP_IMM   = 3'b000;
    localparam logic [2:0] OP_REG_A = 3'b001;
    localparam logic [2:0] OP_REG_B = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_NOP   = 3'b101;
    localparam logic [2:0] OP_REG_C = 3'b110;
    localparam logic [2:0] OP_JUMP  = 3'b111;

    // The bundle carries an 8-bit immediate; the top zero-extends or
    // trims it to its IMM_W output.
    localparam int BUNDLE_IMM_W = 8;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0]              op_code;
        logic [2:0]              r1_address;
        logic [2:0]              r2_address;
        logic [2:0]              writen_address;
        logic [BUNDLE_IMM_W-1:0] imm;
        logic [1:0]              function_code;
        logic [4:0]              jump_address;
        logic                    alu_src;
        logic                    writen_src;
        logic                    reg_writen;
        logic                    mem_writen;
        logic                    mem_read;
        logic                    jump_en;
        logic                    halt;
    } ctrl_bundle_t;

    function automatic logic is_halt(input logic [8:0] instr);
        return (instr[8:6] == OP_IMM) && (instr[1:0] == 2'b11);
    endfunction

    function automatic ctrl_bundle_t decode(input logic [8:0] instr);
        ctrl_bundle_t b;
        b                = '0;
        b.op_code        = instr[8:6];
        b.r1_address     = instr[5:3];
        b.writen_address = instr[5:3];
        b.r2_address     = instr[2:0];
        b.function_code  = instr[1:0];
        b.jump_address   = instr[5:1];
        case (instr[8:6])
            OP_IMM: begin
                if (is_halt(instr)) begin
                    b.halt = 1'b1;
                end else begin
                    b.imm        = BUNDLE_IMM_W'(instr[2]);
                    b.alu_src    = 1'b1;
                    b.writen_src = 1'b1;
                    b.reg_writen = 1'b1;
                end
            end
            OP_REG_A, OP_REG_B, OP_REG_C: begin
                b.writen_src = 1'b1;
                b.reg_writen = 1'b1;
            end
            OP_LOAD: begin
                b.mem_read   = 1'b1;
                b.reg_writen = 1'b1;
            end
            OP_STORE: b.mem_writen = 1'b1;
            OP_NOP: ;
            OP_JUMP: begin
                if (!instr[0]) begin
                    b.jump_en = 1'b1;
                end else begin
                    // Register form of 111 takes its register from [3:1]
                    b.r1_address     = instr[3:1];
                    b.writen_address = instr[3:1];
                    b.writen_src     = 1'b1;
                    b.reg_writen     = 1'b1;
                end
            end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ctrl_inst_fifo.sv
// ctrl_inst_fifo: DEPTH-entry instruction FIFO ({instr, pc} words).
//   clk, srst  : clock, synchronous active-high reset
//   flush      : empties the FIFO at the next edge (wins over push/pop)
//   push/push_data : write one word (caller guarantees !full)
//   pop        : drop the head (caller guarantees !empty)
//   head_data  : current head word, combinational read so the decoder can
//                register the bundle in the same cycle it pops
//   full/empty : occupancy flags
module ctrl_inst_fifo
    import ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 17
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [W-1:0]     entry_data [DEPTH];

    // One register per entry; small enough that a mux read beats a RAM.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [W-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    data_reg <= push_data;
                end
            end
            assign entry_data[gi] = data_reg;
        end
    endgenerate

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = entry_data[rd_ptr_reg];
    assign full      = (count_reg == (PTR_W + 1)'(DEPTH));
    assign empty     = (count_reg == '0);

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: buffered instruction decoder with halt/flush control.
//   Clk, Reset           : clock, synchronous active-high reset
//   in_valid/in_instr/in_pc, in_ready : fetch handshake into the FIFO
//   flush                : drop FIFO and output register (redirect)
//   start                : leave HALTED
//   out_valid/out_ready  : bundle handshake towards execute
//   out_pc, op_code .. Halt : registered decoded bundle
//   halted               : core is in HALTED
// Optional: CTRL_DECODE_PERF_EN adds perf_instr / perf_stall saturating
// 16-bit counters (bundles consumed / cycles stalled by execute).
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 8,
    parameter int IMM_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    input  logic [8:0]       in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             in_ready,
    input  logic             flush,
    input  logic             start,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [PC_W-1:0]  out_pc,
    output logic [2:0]       op_code,
    output logic [2:0]       R1_address,
    output logic [2:0]       R2_address,
    output logic [2:0]       Writen_address,
    output logic [IMM_W-1:0] Imm,
    output logic [1:0]       Function_code,
    output logic [4:0]       Jump_address,
    output logic             ALU_src,
    output logic             Writen_src,
    output logic             Reg_writen,
    output logic             Mem_writen,
    output logic             Mem_read,
    output logic             Jump_en,
    output logic             Halt,
    output logic             halted
`ifdef CTRL_DECODE_PERF_EN
    ,
    output logic [15:0]      perf_instr,
    output logic [15:0]      perf_stall
`endif
);

    localparam int FIFO_W = 9 + PC_W;

    state_t          state_reg;
    logic            halt_seen_reg;
    logic            out_valid_reg;
    ctrl_bundle_t    out_bundle_reg;
    logic [PC_W-1:0] out_pc_reg;

    logic [FIFO_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              consume;
    logic              halt_enter;
    logic              load;

    assign in_ready   = !Reset && (state_reg == RUN) && !halt_seen_reg && !fifo_full;
    assign accept     = in_valid && in_ready && !flush;
    assign consume    = out_valid_reg && out_ready;
    assign halt_enter = consume && out_bundle_reg.halt && (state_reg == RUN) && !flush;
    assign load       = !fifo_empty && (!out_valid_reg || out_ready) && !flush
                        && (state_reg == RUN) && !halt_enter;

    ctrl_inst_fifo #(
        .DEPTH (DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .clk       (Clk),
        .srst      (Reset),
        .flush     (flush || halt_enter),   // halt entry also drops storage
        .push      (accept),
        .push_data ({in_instr, in_pc}),
        .pop       (load),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= RUN;
            halt_seen_reg  <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_bundle_reg <= '0;
            out_pc_reg     <= '0;
        end else if (flush) begin
            // Storage only: a flush never moves the FSM
            out_valid_reg <= 1'b0;
            halt_seen_reg <= 1'b0;
        end else if (state_reg == RUN) begin
            if (accept && is_halt(in_instr)) begin
                halt_seen_reg <= 1'b1;
            end
            if (halt_enter) begin
                state_reg     <= HALTED;
                out_valid_reg <= 1'b0;
            end else if (load) begin
                out_valid_reg  <= 1'b1;
                out_bundle_reg <= decode(fifo_head[FIFO_W-1:PC_W]);
                out_pc_reg     <= fifo_head[PC_W-1:0];
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end else if (start) begin
            state_reg     <= RUN;
            halt_seen_reg <= 1'b0;
        end
    end

    assign out_valid      = out_valid_reg;
    assign out_pc         = out_pc_reg;
    assign op_code        = out_bundle_reg.op_code;
    assign R1_address     = out_bundle_reg.r1_address;
    assign R2_address     = out_bundle_reg.r2_address;
    assign Writen_address = out_bundle_reg.writen_address;
    assign Imm            = IMM_W'(out_bundle_reg.imm);
    assign Function_code  = out_bundle_reg.function_code;
    assign Jump_address   = out_bundle_reg.jump_address;
    assign ALU_src        = out_bundle_reg.alu_src;
    assign Writen_src     = out_bundle_reg.writen_src;
    assign Reg_writen     = out_bundle_reg.reg_writen;
    assign Mem_writen     = out_bundle_reg.mem_writen;
    assign Mem_read       = out_bundle_reg.mem_read;
    assign Jump_en        = out_bundle_reg.jump_en;
    assign Halt           = out_bundle_reg.halt;
    assign halted         = (state_reg == HALTED);

`ifdef CTRL_DECODE_PERF_EN
    logic [15:0] perf_instr_reg;
    logic [15:0] perf_stall_reg;

    // Reset-only clear: a flush must not hide past activity.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            perf_instr_reg <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (consume && (perf_instr_reg != 16'hFFFF)) begin
                perf_instr_reg <= perf_instr_reg + 16'd1;
            end
            if (out_valid_reg && !out_ready && (perf_stall_reg != 16'hFFFF)) begin
                perf_stall_reg <= perf_stall_reg + 16'd1;
            end
        end
    end

    assign perf_instr = perf_instr_reg;
    assign perf_stall = perf_stall_reg;
`endif

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: scoreboard bench for ctrl_decode_pipe.
// Accepted instructions are queued; each consumed bundle is compared with
// an independent reference decode of the queued instruction.
module tb_ctrl_decode_pipe;

    localparam int DEPTH = 4;
    localparam int PC_W  = 8;
    localparam int IMM_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [8:0]       in_instr = '0;
    logic [PC_W-1:0]  in_pc = '0;
    logic             flush = 1'b0;
    logic             start = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready, out_valid, halted;
    logic [PC_W-1:0]  out_pc;
    logic [2:0]       op_code, R1_address, R2_address, Writen_address;
    logic [IMM_W-1:0] Imm;
    logic [1:0]       Function_code;
    logic [4:0]       Jump_address;
    logic             ALU_src, Writen_src, Reg_writen, Mem_writen, Mem_read, Jump_en, Halt;
`ifdef CTRL_DECODE_PERF_EN
    logic [15:0]      perf_instr, perf_stall;
`endif

    always #5 clk = ~clk;

    ctrl_decode_pipe #(.DEPTH(DEPTH), .PC_W(PC_W), .IMM_W(IMM_W)) dut (
        .Clk(clk), .Reset(rst),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .flush(flush), .start(start), .out_ready(out_ready),
        .out_valid(out_valid), .out_pc(out_pc),
        .op_code(op_code), .R1_address(R1_address), .R2_address(R2_address),
        .Writen_address(Writen_address), .Imm(Imm), .Function_code(Function_code),
        .Jump_address(Jump_address), .ALU_src(ALU_src), .Writen_src(Writen_src),
        .Reg_writen(Reg_writen), .Mem_writen(Mem_writen), .Mem_read(Mem_read),
        .Jump_en(Jump_en), .Halt(Halt), .halted(halted)
`ifdef CTRL_DECODE_PERF_EN
        , .perf_instr(perf_instr), .perf_stall(perf_stall)
`endif
    );

    wire [33:0] act_vec = {op_code, R1_address, R2_address, Writen_address, Imm,
                           Function_code, Jump_address, ALU_src, Writen_src,
                           Reg_writen, Mem_writen, Mem_read, Jump_en, Halt};

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [8:0]      instr;
    } txn_t;

    txn_t            sb[$];
    txn_t            exp_t;
    int              n_checks = 0;
    int              n_pass   = 0;
    logic            took;
    logic [33:0]     gv;
    logic [PC_W-1:0] gp;

    // Reference decode written as an encoding table.
    // ctl = {ALU_src, Writen_src, Reg_writen, Mem_writen, Mem_read, Jump_en, Halt}
    function automatic logic [33:0] ref_decode(input logic [8:0] i);
        logic [2:0] r1, wr;
        logic [7:0] imm;
        logic [6:0] ctl;
        r1 = i[5:3]; wr = i[5:3]; imm = 8'd0; ctl = 7'd0;
        casez (i)
            9'b000????11: ctl = 7'b0000001;
            9'b000??????: begin ctl = 7'b1110000; imm = {7'd0, i[2]}; end
            9'b001??????, 9'b010??????, 9'b110??????: ctl = 7'b0110000;
            9'b011??????: ctl = 7'b0010100;
            9'b100??????: ctl = 7'b0001000;
            9'b111?????0: ctl = 7'b0000010;
            9'b111?????1: begin ctl = 7'b0110000; r1 = i[3:1]; wr = i[3:1]; end
            default:      ctl = 7'd0;
        endcase
        return {i[8:6], r1, i[2:0], wr, imm, i[1:0], i[5:1], ctl};
    endfunction

    // One cycle: capture the visible bundle, drive inputs for the next edge,
    // and queue the instruction if it will be accepted at that edge.
    task automatic step(input logic v, input logic [8:0] ins, input logic [PC_W-1:0] pc,
                        input logic fl, input logic st, input logic ordy);
        @(negedge clk);
        took      = out_valid && ordy && !fl;
        gv        = act_vec;
        gp        = out_pc;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        flush     = fl;
        start     = st;
        out_ready = ordy;
        if (fl) sb.delete();
        else if (v && in_ready) sb.push_back('{pc: pc, instr: ins});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, halted, in_ready} !== 3'b000) $display("FAIL reset_flags: got v/h/r=%b want 000", {out_valid, halted, in_ready});
        else n_pass++;
        n_checks++;
        if ({act_vec, out_pc} !== '0) $display("FAIL reset_bundle: got %h/%h want 0", act_vec, out_pc);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_alu_imm();
        step(1, 9'b000101100, 8'h10, 0, 0, 1);
        step(0, 9'd0, 8'h00, 0, 0, 1);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL alu_latency_early: got out_valid=%b want 0", out_valid);
        else n_pass++;
        step(0, 9'd0, 8'h00, 0, 0, 1);
        n_checks++;
        if (took !== 1'b1) $display("FAIL alu_latency: got out_valid=%b want 1", took);
        else n_pass++;
        n_checks++;
        if ({Imm, Writen_address, ALU_src, Reg_writen, out_pc} !== {8'd1, 3'd5, 1'b1, 1'b1, 8'h10})
            $display("FAIL alu_fields: got imm=%0d wr=%0d alu=%b rw=%b pc=%h want 1 5 1 1 10",
                     Imm, Writen_address, ALU_src, Reg_writen, out_pc);
        else n_pass++;
        if (took) begin
            n_checks++;
            if (sb.size() == 0) $display("FAIL alu_sb: unexpected bundle pc=%h", gp);
            else begin
                exp_t = sb.pop_front();
                if (gv !== ref_decode(exp_t.instr) || gp !== exp_t.pc)
                    $display("FAIL alu_sb: got pc=%h bundle=%h want pc=%h bundle=%h", gp, gv, exp_t.pc, ref_decode(exp_t.instr));
                else n_pass++;
            end
        end
    endtask

    task automatic test_reg111();
        step(1, 9'b111001101, 8'h21, 0, 0, 1);
        for (int k = 0; k < 6 && sb.size() != 0; k++) begin
            step(0, 9'd0, 8'h00, 0, 0, 1);
            if (took) begin
                n_checks++;
                if ({R1_address, Writen_address, Writen_src, Reg_writen, Jump_en} !== {3'd6, 3'd6, 1'b1, 1'b1, 1'b0})
                    $display("FAIL reg111_fields: got r1=%0d wr=%0d ws=%b rw=%b je=%b want 6 6 1 1 0",
                             R1_address, Writen_address, Writen_src, Reg_writen, Jump_en);
                else n_pass++;
                n_checks++;
                exp_t = sb.pop_front();
                if (gv !== ref_decode(exp_t.instr) || gp !== exp_t.pc)
                    $display("FAIL reg111_sb: got pc=%h bundle=%h want pc=%h bundle=%h", gp, gv, exp_t.pc, ref_decode(exp_t.instr));
                else n_pass++;
            end
        end
        n_checks++;
        if (sb.size() != 0) $display("FAIL reg111_drain: got %0d pending want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [8:0] bp_instr [6] = '{9'b001010011, 9'b011100001, 9'b100011010,
                                     9'b101000000, 9'b110111111, 9'b010001001};
        logic       exp_rdy  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(1, bp_instr[i], 8'h40 + 8'(i), 0, 0, 0);
            n_checks++;
            if (in_ready !== exp_rdy[i]) $display("FAIL bp_in_ready[%0d]: got %b want %b", i, in_ready, exp_rdy[i]);
            else n_pass++;
        end
        step(0, 9'd0, 8'h00, 0, 0, 0);
        n_checks++;
        if ({out_valid, in_ready} !== 2'b10) $display("FAIL bp_full: got v/r=%b want 10", {out_valid, in_ready});
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step(0, 9'd0, 8'h00, 0, 0, 1);
            n_checks++;
            if (took !== 1'b1) $display("FAIL bp_throughput[%0d]: got valid=%b want 1", i, took);
            else n_pass++;
            if (took) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL bp_sb: unexpected bundle pc=%h", gp);
                else begin
                    exp_t = sb.pop_front();
                    if (gv !== ref_decode(exp_t.instr) || gp !== exp_t.pc)
                        $display("FAIL bp_sb: got pc=%h bundle=%h want pc=%h bundle=%h", gp, gv, exp_t.pc, ref_decode(exp_t.instr));
                    else n_pass++;
                end
            end
        end
        step(0, 9'd0, 8'h00, 0, 0, 1);
        n_checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) $display("FAIL bp_empty: got out_valid=%b pending=%0d want 0 0", out_valid, sb.size());
        else n_pass++;
    endtask

    task automatic test_halt();
        step(1, 9'b000000011, 8'h30, 0, 0, 0);
        step(1, 9'b001010011, 8'h31, 0, 0, 0);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL halt_blocks_input: got in_ready=%b want 0", in_ready);
        else n_pass++;
        step(0, 9'd0, 8'h00, 0, 0, 1);
        n_checks++;
        if ({took, Halt} !== 2'b11) $display("FAIL halt_bundle: got valid/halt=%b want 11", {took, Halt});
        else n_pass++;
        if (took) begin
            n_checks++;
            exp_t = sb.pop_front();
            if (gv !== ref_decode(exp_t.instr) || gp !== exp_t.pc)
                $display("FAIL halt_sb: got pc=%h bundle=%h want pc=%h bundle=%h", gp, gv, exp_t.pc, ref_decode(exp_t.instr));
            else n_pass++;
        end
        step(0, 9'd0, 8'h00, 0, 0, 1);
        n_checks++;
        if ({halted, out_valid, in_ready} !== 3'b100) $display("FAIL halted_state: got h/v/r=%b want 100", {halted, out_valid, in_ready});
        else n_pass++;
        step(0, 9'd0, 8'h00, 0, 1, 1);
        step(0, 9'd0, 8'h00, 0, 0, 1);
        n_checks++;
        if ({halted, in_ready, out_valid} !== 3'b010) $display("FAIL restart: got h/r/v=%b want 010", {halted, in_ready, out_valid});
        else n_pass++;
        n_checks++;
        if (sb.size() != 0) $display("FAIL halt_refused: got %0d pending want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_flush();
        int seen;
        logic [8:0] fl_instr [3] = '{9'b011001010, 9'b110010100, 9'b100101110};
        for (int i = 0; i < 3; i++) step(1, fl_instr[i], 8'h50 + 8'(i), 0, 0, 0);
        step(1, 9'b010010010, 8'h5F, 1, 0, 0);
        step(0, 9'd0, 8'h00, 0, 0, 1);
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL flush_out_valid: got v/r=%b want 01", {out_valid, in_ready});
        else n_pass++;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 9'd0, 8'h00, 0, 0, 1);
            if (took) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL flush_empty: got %0d bundles want 0", seen);
        else n_pass++;
        // Flush also forgets a pending halt
        step(1, 9'b000111011, 8'h5A, 0, 0, 0);
        step(0, 9'd0, 8'h00, 1, 0, 0);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL flush_halt_seen_set: got in_ready=%b want 0", in_ready);
        else n_pass++;
        step(0, 9'd0, 8'h00, 0, 0, 1);
        n_checks++;
        if ({in_ready, out_valid, halted} !== 3'b100) $display("FAIL flush_clears_halt_seen: got r/v/h=%b want 100", {in_ready, out_valid, halted});
        else n_pass++;
        step(1, 9'b100110001, 8'h60, 0, 0, 1);
        for (int k = 0; k < 6 && sb.size() != 0; k++) begin
            step(0, 9'd0, 8'h00, 0, 0, 1);
            if (took) begin
                n_checks++;
                exp_t = sb.pop_front();
                if (gv !== ref_decode(exp_t.instr) || gp !== exp_t.pc)
                    $display("FAIL flush_after_sb: got pc=%h bundle=%h want pc=%h bundle=%h", gp, gv, exp_t.pc, ref_decode(exp_t.instr));
                else n_pass++;
            end
        end
        n_checks++;
        if (sb.size() != 0) $display("FAIL flush_after_drain: got %0d pending want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [8:0] ins;
        for (int i = 0; i < 12; i++) begin
            ins = 9'($urandom);
            if (ins[8:6] == 3'b000) ins[1] = 1'b0;
            step(1, ins, 8'h70 + 8'(i), 0, 0, 1);
            n_checks++;
            if ({in_ready, took} !== {1'b1, (i >= 2)}) $display("FAIL b2b_rate[%0d]: got r/v=%b want 1%b", i, {in_ready, took}, (i >= 2));
            else n_pass++;
            if (took) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL b2b_sb: unexpected bundle pc=%h", gp);
                else begin
                    exp_t = sb.pop_front();
                    if (gv !== ref_decode(exp_t.instr) || gp !== exp_t.pc)
                        $display("FAIL b2b_sb: got pc=%h bundle=%h want pc=%h bundle=%h", gp, gv, exp_t.pc, ref_decode(exp_t.instr));
                    else n_pass++;
                end
            end
        end
        for (int k = 0; k < 6 && sb.size() != 0; k++) begin
            step(0, 9'd0, 8'h00, 0, 0, 1);
            if (took) begin
                n_checks++;
                exp_t = sb.pop_front();
                if (gv !== ref_decode(exp_t.instr) || gp !== exp_t.pc)
                    $display("FAIL b2b_tail_sb: got pc=%h bundle=%h want pc=%h bundle=%h", gp, gv, exp_t.pc, ref_decode(exp_t.instr));
                else n_pass++;
            end
        end
        n_checks++;
        if (sb.size() != 0) $display("FAIL b2b_drain: got %0d pending want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen;
        step(1, 9'b001001001, 8'h80, 0, 0, 0);
        step(1, 9'b011011011, 8'h81, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, halted} !== 3'b000) $display("FAIL reset_mid: got v/r/h=%b want 000", {out_valid, in_ready, halted});
        else n_pass++;
        rst = 1'b0; start = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 9'd0, 8'h00, 0, 0, 1);
            if (took) seen++;
        end
        n_checks++;
        if (seen != 0 || in_ready !== 1'b1) $display("FAIL reset_mid_discard: got %0d bundles ready=%b want 0 1", seen, in_ready);
        else n_pass++;
    endtask

    task automatic test_jump();
        step(1, 9'b111101010, 8'h55, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 9'd0, 8'h00, 0, 0, 0);
        step(0, 9'd0, 8'h00, 0, 0, 1);
        n_checks++;
        if ({took, Jump_address, Jump_en, Reg_writen} !== {1'b1, 5'd21, 1'b1, 1'b0})
            $display("FAIL jump_fields: got v=%b ja=%0d je=%b rw=%b want 1 21 1 0", took, Jump_address, Jump_en, Reg_writen);
        else n_pass++;
        if (took) begin
            n_checks++;
            exp_t = sb.pop_front();
            if (gv !== ref_decode(exp_t.instr) || gp !== exp_t.pc)
                $display("FAIL jump_sb: got pc=%h bundle=%h want pc=%h bundle=%h", gp, gv, exp_t.pc, ref_decode(exp_t.instr));
            else n_pass++;
        end
        step(0, 9'd0, 8'h00, 0, 0, 1);
`ifdef CTRL_DECODE_PERF_EN
        n_checks++;
        if (perf_instr !== 16'd1) $display("FAIL perf_instr: got %0d want 1", perf_instr);
        else n_pass++;
        n_checks++;
        if (perf_stall !== 16'd3) $display("FAIL perf_stall: got %0d want 3", perf_stall);
        else n_pass++;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_imm();
        test_reg111();
        test_backpressure();
        test_halt();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_jump();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_pipe.md
# ctrl_decode_pipe

Registered, buffered successor to the single-cycle instruction decoder. It accepts 9-bit instructions, with their PC, from fetch over a valid/ready handshake and holds them in a DEPTH-entry instruction FIFO. It decodes the FIFO head into a registered control bundle for execute, and owns the processor halt state, the flush on redirect and restart.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- PC_W, 8: width of the PC tag carried with each instruction.
- IMM_W, 8: immediate width; zero-extended.
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- in_valid / in_instr / in_pc  in  1 / 9 / PC_W  fetch request.
- in_ready  out  1  FIFO can accept.
- flush  in  1  drop FIFO and output register (branch redirect).
- start  in  1  leave HALTED.
- out_ready  in  1  execute consumes bundle.
- out_valid  out  1  bundle valid.
- out_pc  out  PC_W  PC tag of the bundle.
- op_code, R1_address, R2_address, Writen_address  out  3 each  decoded fields.
- Imm  out  IMM_W  decoded immediate.
- Function_code  out  2  decoded field.
- Jump_address  out  5  decoded field.
- ALU_src, Writen_src, Reg_writen, Mem_writen, Mem_read, Jump_en, Halt  out  1 each  control bits.
- halted  out  1  core halted.

## Operation
- Decode rules on instr i, opcode i[8:6]:
  - Default fields: op_code=i[8:6], R1=Writen=i[5:3], R2=i[2:0], Function_code=i[1:0], Jump_address=i[5:1], Imm=0.
  - 000 with i[1:0]!=11: ALU-immediate. Imm=i[2] zero-extended. Controls ALU_src=1, Writen_src=1, Reg_writen=1.
  - 000 with i[1:0]=11: halt. Halt=1; all other controls 0.
  - 001, 010, 110: register ALU op. Writen_src=1, Reg_writen=1.
  - 011: load. Mem_read=1, Reg_writen=1, Writen_src=0.
  - 100: store. Mem_writen=1.
  - 101: nop. All controls 0.
  - 111 with i[0]=0: jump. Jump_en=1.
  - 111 with i[0]=1: register op with R1=Writen=i[3:1]. Writen_src=1, Reg_writen=1.
- Acceptance:
  - Accept = in_valid & in_ready & !flush.
  - in_ready = !Reset & state==RUN & !halt_seen & count<DEPTH.
  - There is no pass-through when the FIFO is full.
- Output load:
  - Condition: FIFO non-empty & (!out_valid | out_ready) & !flush & state==RUN.
  - Action: pop the head, register its decoded bundle and PC, and set out_valid.
  - Otherwise: out_valid clears on out_ready, and the bundle holds while out_valid & !out_ready.
- Halt FSM, states RUN and HALTED:
  - Accepting a halt instruction sets halt_seen, which blocks further input.
  - RUN→HALTED on the cycle a bundle with Halt=1 is consumed (out_valid & out_ready). The FIFO is then cleared and out_valid=0.
  - HALTED: halted=1, in_ready=0. start→RUN and clears halt_seen.
- Flush:
  - At the next edge: FIFO empty, out_valid=0, halt_seen=0.
  - Flush has priority over push, pop and halt entry.
  - In HALTED, flush clears storage only; the state stays HALTED.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - All outputs 0 except halted=0 and in_ready=0.
  - State RUN, count=0, pointers=0, halt_seen=0.
- Latency: an instruction accepted at edge N appears at out_valid after edge N+1 if the FIFO was empty and the output register was free.
- Throughput: 1 instruction/cycle with out_ready held high.
- Reset mid-operation: all state is discarded at that edge.
- Reset and start asserted together: Reset wins.

## Configuration
- CTRL_DECODE_PERF_EN defined: adds outputs perf_instr (16b), which counts bundles consumed, and perf_stall (16b), which counts cycles with out_valid & !out_ready.
  - Both counters saturate at 0xFFFF.
  - Reset clears both counters; flush does not.
- CTRL_DECODE_PERF_EN undefined: the ports and counters are absent.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams;
  - ctrl_bundle_t, a packed struct of all decoded outputs;
  - state_t enum {RUN, HALTED};
  - the automatic function decode(logic [8:0]) returning ctrl_bundle_t.
- Sub-module ctrl_inst_fifo holds the DEPTH×(9+PC_W) storage, pointers, count, flush and full/empty flags.

## Test plan
- ALU-immediate: push 9'b000101100, pc 0x10 → out_valid 2 cycles later; Imm=1, Writen_address=5, ALU_src=1, Reg_writen=1, out_pc=0x10.
- Register op on 111: push 9'b111001101 → R1_address=Writen_address=6, Writen_src=1, Reg_writen=1, Jump_en=0.
- Backpressure, DEPTH=4: out_ready=0 and 6 instructions offered → 1 in the output register plus 4 in the FIFO; in_ready=0. Release out_ready → 5 bundles in order, 1 per cycle.
- Halt: push 9'b000000011, then 9'b001010011 → the second instruction is refused. Halt bundle consumed → halted=1 next cycle. start → in_ready=1.
- Flush: 3 queued, flush high for one cycle with in_valid=1 → next cycle out_valid=0, count=0; the flushed-cycle instruction is not accepted.
- Jump, with CTRL_DECODE_PERF_EN: push 9'b111101010 → Jump_address=21, Jump_en=1; perf_instr=1 after consumption.
